// File: rtl/bundle_pkg.sv
// Bundle encoding shared by the issue sequencer, the control circuit and the bench:
// opcode values, field slices of the 32-bit two-slot bundle, and the issue FSM states.
package bundle_pkg;

  localparam logic [4:0] OP1_NOP  = 5'b00000;
  localparam logic [4:0] OP1_ALU  = 5'b01000;
  localparam logic [4:0] OP1_ALUI = 5'b00101;

  localparam logic [4:0] OP2_NOP  = 5'b00000;
  localparam logic [4:0] OP2_LD   = 5'b01010;
  localparam logic [4:0] OP2_ST   = 5'b01011;
  localparam logic [4:0] OP2_JMP  = 5'b11110;
  localparam logic [4:0] OP2_BR   = 5'b11011;

  typedef enum logic [1:0] {IDLE, ISSUE, MEM, RESOLVE} state_t;

  function automatic logic [4:0] op1_of(input logic [31:0] b);
    return b[4:0];
  endfunction

  function automatic logic [2:0] fn1_of(input logic [31:0] b);
    return b[7:5];
  endfunction

  function automatic logic [2:0] rd1_of(input logic [31:0] b);
    return b[10:8];
  endfunction

  function automatic logic [2:0] rs1_of(input logic [31:0] b);
    return b[13:11];
  endfunction

  function automatic logic [4:0] op2_of(input logic [31:0] b);
    return b[20:16];
  endfunction

  function automatic logic [2:0] rt2_of(input logic [31:0] b);
    return b[23:21];
  endfunction

  function automatic logic [2:0] base2_of(input logic [31:0] b);
    return b[26:24];
  endfunction

endpackage

// File: rtl/hazard_check.sv
// Load-use detector: flags an incoming bundle that reads the register a completed load is writing.
// Purely combinational, no backpressure of its own; the sequencer turns a hit into a one-cycle bubble.
module hazard_check
  import bundle_pkg::*;
(
  input  logic       pend,
  input  logic [2:0] dest,
  input  logic [4:0] op1,
  input  logic [2:0] rd1,
  input  logic [2:0] rs1,
  input  logic [4:0] op2,
  input  logic [2:0] rt2,
  input  logic [2:0] base2,
  output logic       hazard
);

  logic slot1_reads;
  logic slot2_reads;

  // rd1 counts as a source: slot-1 ALU forms read-modify-write their destination.
  assign slot1_reads = (op1 != OP1_NOP) && ((rs1 == dest) || (rd1 == dest));
  assign slot2_reads = ((op2 == OP2_LD) || (op2 == OP2_ST)) &&
                       ((base2 == dest) || (rt2 == dest));

  assign hazard = pend && (slot1_reads || slot2_reads);

endmodule

// File: rtl/bundle_issue_ctrl.sv
// Issue sequencer: one bundle per cycle from fetch, held for slot-2 memory waits and branch resolve.
// Zero-cycle issue path; ir_ready drops in MEM/RESOLVE and for one cycle on a load-use hit.
module bundle_issue_ctrl
  import bundle_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ir_valid,
  input  logic [31:0]      ir,
  output logic             ir_ready,
  output logic             pc_write,
  output logic [31:0]      issue_ir,
  input  logic             n_cntrl,
  output logic             mem_req,
  input  logic             mem_ack,
  output logic             flush,
  output logic             stall,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int                WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  state_t            state_q, state_d;
  logic [31:0]       cur_ir_q;
  logic [WAIT_W-1:0] wait_q;
  logic              load_pend_q;
  logic [2:0]        load_dest_q;
  logic              hazard;
  logic              capture;
  logic              set_pend;
  logic              clr_pend;
  logic              mem_timeout;

  hazard_check u_hazard (
    .pend   (load_pend_q),
    .dest   (load_dest_q),
    .op1    (op1_of(ir)),
    .rd1    (rd1_of(ir)),
    .rs1    (rs1_of(ir)),
    .op2    (op2_of(ir)),
    .rt2    (rt2_of(ir)),
    .base2  (base2_of(ir)),
    .hazard (hazard)
  );

  always_comb begin
    state_d     = state_q;
    ir_ready    = 1'b0;
    pc_write    = 1'b0;
    issue_ir    = 32'h0;
    mem_req     = 1'b0;
    flush       = 1'b0;
    stall       = 1'b0;
    capture     = 1'b0;
    set_pend    = 1'b0;
    clr_pend    = 1'b0;
    mem_timeout = 1'b0;
    case (state_q)
      IDLE: state_d = ISSUE;
      ISSUE: begin
        if (ir_valid && hazard) begin
          // One bubble is enough: the load result is written back by the next cycle.
          stall    = 1'b1;
          clr_pend = 1'b1;
        end else begin
          ir_ready = 1'b1;
          if (ir_valid) begin
            pc_write = 1'b1;
            issue_ir = ir;
            capture  = 1'b1;
            clr_pend = 1'b1;
            if ((op2_of(ir) == OP2_LD) || (op2_of(ir) == OP2_ST)) begin
              state_d = MEM;
            end else if ((op2_of(ir) == OP2_JMP) || (op2_of(ir) == OP2_BR)) begin
              state_d = RESOLVE;
            end
          end
        end
      end
      MEM: begin
        mem_req  = 1'b1;
        issue_ir = cur_ir_q;
        stall    = 1'b1;
        if (mem_ack) begin
          state_d  = ISSUE;
          set_pend = (op2_of(cur_ir_q) == OP2_LD);
        end else if (wait_q == WAIT_MAX) begin
          mem_timeout = 1'b1;
          state_d     = ISSUE;
        end
      end
      RESOLVE: begin
        issue_ir = cur_ir_q;
        state_d  = ISSUE;
        if ((op2_of(cur_ir_q) == OP2_JMP) ||
            ((op2_of(cur_ir_q) == OP2_BR) && n_cntrl)) begin
          flush    = 1'b1;
          pc_write = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cur_ir_q    <= 32'h0;
      wait_q      <= '0;
      load_pend_q <= 1'b0;
      load_dest_q <= 3'd0;
      mem_err     <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        cur_ir_q <= ir;
      end
      if ((state_d == MEM) && (state_q != MEM)) begin
        wait_q <= WAIT_W'(1);
      end else if (state_q == MEM) begin
        wait_q <= wait_q + 1'b1;
      end
      if (set_pend) begin
        load_pend_q <= 1'b1;
        load_dest_q <= rt2_of(cur_ir_q);
      end else if (clr_pend) begin
        load_pend_q <= 1'b0;
      end
      if (mem_timeout) begin
        mem_err <= 1'b1;
      end
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  logic unused_fields;
  assign unused_fields = ^{fn1_of(ir), OP1_ALU, OP1_ALUI, OP2_NOP};

endmodule
